// File: rtl/mod_n_counter_pkg.sv
// Shared definitions for the modulo-N counter: the runtime mode encoding.
package mod_n_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-count logic: terminal-count detect, step, and the
// wrap/saturate/one-shot decision at the end of the range.
module mod_n_next
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic [1:0]       mode_i,
  input  logic             done_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             wrap_evt_o,
  output logic             set_done_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  mode_e mode;
  assign mode = mode_e'(mode_i);
  assign tc_o = up_i ? (q_i == MAX_Q) : (q_i == '0);

  // Steps only happen away from the range ends, so q+/-1 never needs a carry bit.
  always_comb begin
    next_q_o   = q_i;
    wrap_evt_o = 1'b0;
    set_done_o = 1'b0;
    if (!(mode == MODE_ONESHOT && done_i)) begin
      if (!tc_o) begin
        next_q_o = up_i ? (q_i + WIDTH'(1)) : (q_i - WIDTH'(1));
      end else begin
        case (mode)
          MODE_SAT:     next_q_o   = q_i;
          MODE_ONESHOT: set_done_o = 1'b1;
          default: begin
            next_q_o   = up_i ? '0 : MAX_Q;
            wrap_evt_o = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with load, clear, modes, carry pulse
// and wrap-event counter. Priority: reset > clear > load > en.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic [1:0]        mode,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              carry,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0]  q_q, q_d, next_q, load_q;
  logic              carry_q, carry_d, done_q, done_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              wrap_evt, set_done;

  mod_n_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .q_i        (q_q),
    .up_i       (up),
    .mode_i     (mode),
    .done_i     (done_q),
    .next_q_o   (next_q),
    .wrap_evt_o (wrap_evt),
    .set_done_o (set_done),
    .tc_o       (tc)
  );

  // Out-of-range load values clamp to the top of the range.
  assign load_q = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_Q;

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    done_d  = done_q;
    wraps_d = wraps_q;
    if (clear) begin
      q_d     = '0;
      done_d  = 1'b0;
      wraps_d = '0;
    end else if (load) begin
      q_d    = load_q;
      done_d = 1'b0;
    end else if (en) begin
      q_d     = next_q;
      carry_d = wrap_evt;
      done_d  = done_q | set_done;
      if (wrap_evt) wraps_d = wraps_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      wraps_q <= wraps_d;
    end
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign done  = done_q;
  assign wraps = wraps_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench: stimulus pushes hand-derived expectations, a monitor
// compares them against the selected DUT (MODULUS=10 or MODULUS=16).
module tb_mod_n_counter;
  import mod_n_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] load_val = '0;

  logic [3:0] q10, q16;
  logic       tc10, tc16, carry10, carry16, done10, done16;
  logic [7:0] wraps10, wraps16;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         sel;
    logic [3:0] q;
    logic       tc, carry, done;
    logic [7:0] wraps;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(8)) u_dut10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .clear(clear),
    .load(load), .load_val(load_val), .q(q10), .tc(tc10), .carry(carry10),
    .done(done10), .wraps(wraps10)
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(16), .WRAP_W(8)) u_dut16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .clear(clear),
    .load(load), .load_val(load_val), .q(q16), .tc(tc16), .carry(carry16),
    .done(done16), .wraps(wraps16)
  );

  // Inputs change on the falling edge; the expectation describes the state
  // after the following rising edge.
  task automatic step(input logic r, input logic c, input logic l, input logic e,
                      input logic u, input logic [1:0] m, input logic [3:0] lv,
                      input bit s, input logic [3:0] eq, input logic etc,
                      input logic ec, input logic ed, input logic [7:0] ew,
                      input string nm);
    exp_t x;
    @(negedge clk);
    reset = r; clear = c; load = l; en = e; up = u; mode = m; load_val = lv;
    @(posedge clk);
    x.sel = s; x.q = eq; x.tc = etc; x.carry = ec; x.done = ed; x.wraps = ew;
    x.name = nm;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [3:0] aq;
    logic       atc, ac, ad;
    logic [7:0] aw;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        aq  = x.sel ? q16 : q10;
        atc = x.sel ? tc16 : tc10;
        ac  = x.sel ? carry16 : carry10;
        ad  = x.sel ? done16 : done10;
        aw  = x.sel ? wraps16 : wraps10;
        tests++;
        if (aq !== x.q || atc !== x.tc || ac !== x.carry || ad !== x.done || aw !== x.wraps) begin
          fails++;
          $display("FAIL %s: got q=%0d tc=%b carry=%b done=%b wraps=%0d, want q=%0d tc=%b carry=%b done=%b wraps=%0d",
                   x.name, aq, atc, ac, ad, aw, x.q, x.tc, x.carry, x.done, x.wraps);
        end
      end
    end
  end

  initial begin : stim
    int k;
    // Reset state
    step(1,0,0,0,1,2'b00,4'd0, 0, 4'd0,0,0,0,8'd0, "reset");
    // Wrap up 25 cycles: q=k%10, carry after each 9->0
    for (k = 1; k <= 25; k++)
      step(0,0,0,1,1,2'b00,4'd0, 0, 4'(k % 10), (k % 10) == 9, (k % 10) == 0, 0,
           8'(k / 10), "wrap_up");
    // Load 3, count down through 0 to 9
    step(0,0,1,1,0,2'b00,4'd3, 0, 4'd3,0,0,0,8'd2, "load3");
    step(0,0,0,1,0,2'b00,4'd0, 0, 4'd2,0,0,0,8'd2, "down2");
    step(0,0,0,1,0,2'b00,4'd0, 0, 4'd1,0,0,0,8'd2, "down1");
    step(0,0,0,1,0,2'b00,4'd0, 0, 4'd0,1,0,0,8'd2, "down0_tc");
    step(0,0,0,1,0,2'b00,4'd0, 0, 4'd9,0,1,0,8'd3, "down_wrap");
    step(0,0,0,0,0,2'b00,4'd0, 0, 4'd9,0,0,0,8'd3, "en0_hold");
    step(0,0,1,0,1,2'b00,4'd12,0, 4'd9,1,0,0,8'd3, "load_clamp");
    // Saturate from 0
    step(0,1,0,0,1,2'b01,4'd0, 0, 4'd0,0,0,0,8'd0, "clear_sat");
    for (k = 1; k <= 15; k++)
      step(0,0,0,1,1,2'b01,4'd0, 0, (k >= 9) ? 4'd9 : 4'(k), k >= 9, 0, 0, 8'd0, "sat_up");
    // One-shot from 0
    step(0,1,0,0,1,2'b10,4'd0, 0, 4'd0,0,0,0,8'd0, "clear_os");
    for (k = 1; k <= 9; k++)
      step(0,0,0,1,1,2'b10,4'd0, 0, 4'(k), k == 9, 0, 0, 8'd0, "os_up");
    step(0,0,0,1,1,2'b10,4'd0, 0, 4'd9,1,0,1,8'd0, "os_done");
    step(0,0,0,1,1,2'b10,4'd0, 0, 4'd9,1,0,1,8'd0, "os_hold");
    step(0,0,0,1,0,2'b10,4'd0, 0, 4'd9,0,0,1,8'd0, "os_hold_down");
    step(0,0,1,0,1,2'b10,4'd5, 0, 4'd5,0,0,0,8'd0, "os_load_undone");
    step(0,1,0,1,1,2'b10,4'd0, 0, 4'd0,0,0,0,8'd0, "os_clear");
    // Priority
    step(0,0,1,0,1,2'b00,4'd4, 0, 4'd4,0,0,0,8'd0, "pre_load4");
    step(0,1,1,1,1,2'b00,4'd7, 0, 4'd0,0,0,0,8'd0, "clear_beats_load");
    step(0,0,1,0,1,2'b00,4'd9, 0, 4'd9,1,0,0,8'd0, "pre_load9");
    step(0,0,0,1,1,2'b00,4'd0, 0, 4'd0,0,1,0,8'd1, "pre_wrap");
    step(1,1,1,1,1,2'b00,4'd5, 0, 4'd0,0,0,0,8'd0, "reset_all");
    step(0,0,0,1,1,2'b00,4'd0, 0, 4'd1,0,0,0,8'd0, "first_after_reset");
    // MODULUS = 2**WIDTH
    step(1,0,0,0,1,2'b00,4'd0, 1, 4'd0,0,0,0,8'd0, "m16_reset");
    for (k = 1; k <= 17; k++)
      step(0,0,0,1,1,2'b00,4'd0, 1, 4'(k % 16), (k % 16) == 15, k == 16, 0,
           8'(k / 16), "m16_up");
    step(0,1,0,0,0,2'b00,4'd0, 1, 4'd0,1,0,0,8'd0, "m16_clear");
    step(0,0,0,1,0,2'b00,4'd0, 1, 4'd15,0,1,0,8'd1, "m16_down_wrap");
    step(0,0,1,0,1,2'b00,4'd12,1, 4'd12,0,0,0,8'd1, "m16_load12");

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #3;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
- Parametrised synchronous modulo-N counter; the general-purpose successor to the team's fixed 4-bit mod-16 up-counter.
- Adds configurable width and modulus, up/down direction, synchronous load and clear, count enable, and runtime-selectable wrap/saturate/one-shot modes.
- Provides a combinational terminal-count flag, a registered carry pulse for cascading, and a wrap-event counter.
- Used as a timer/prescaler/sequencer primitive across the design.

Parameters:
- WIDTH, 4, counter register width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal range is 2..2**WIDTH; any other value is an elaboration error.
- WRAP_W, 8, width of the wrap-event counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; clock clk.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- clear  in  1  synchronous clear of q, done and wraps.
- load  in  1  synchronous load of q from load_val.
- load_val  in  WIDTH  load value.
- q  out  WIDTH  current count (registered).
- tc  out  1  combinational terminal count: q==MODULUS-1 when up=1, q==0 when up=0.
- carry  out  1  registered one-cycle pulse when a wrap occurs.
- done  out  1  one-shot completion flag (registered, sticky).
- wraps  out  WRAP_W  number of wraps since reset/clear, modulo 2**WRAP_W.

Behaviour:
- Reset values: q=0, carry=0, done=0, wraps=0.
- Priority per cycle: reset > clear > load > en.
- clear:
  - q<=0, done<=0, wraps<=0, carry<=0.
  - Takes effect regardless of en.
- load:
  - q <= load_val if load_val < MODULUS; otherwise q <= MODULUS-1 (clamped).
  - done<=0, carry<=0, wraps unchanged.
- Count step (en=1, no clear/load):
  - If tc=0: q <= q+1 when up=1, q-1 when up=0. carry<=0.
  - If tc=1, mode wrap: q wraps (MODULUS-1 -> 0 up; 0 -> MODULUS-1 down). carry<=1, wraps<=wraps+1 (wraps around silently).
  - If tc=1, mode saturate: q holds, carry<=0, wraps unchanged.
  - If tc=1, mode one-shot: q holds, done<=1, carry<=0.
- done:
  - Once set, done holds until clear, load, or reset.
  - While done=1 in one-shot mode, en has no effect on q.
- en=0: q, done and wraps hold; carry<=0.
- Arithmetic: no intermediate wider than WIDTH+1 bits. q never leaves 0..MODULUS-1, including when MODULUS=2**WIDTH.
- Latency:
  - q, carry, done and wraps change on the clock edge after the inputs are sampled.
  - tc reflects the current q and up combinationally.
- Direction or mode changes mid-count take effect in the same cycle they are sampled. tc re-evaluates immediately against the new up value.
- Reset mid-operation overrides everything; the first count after reset deasserts starts from 0.

Decomposition:
- Shared package: mode encoding constants (MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10).
- One natural sub-module: mod_n_next. It is combinational; it takes q, up, mode and done, and produces next_q, wrap_evt and set_done.
- The top level holds the registers, priority logic and the wraps counter.

Test Plan (WIDTH=4, MODULUS=10, WRAP_W=8 unless noted):
- Reset, then en=1, up=1, mode=wrap for 25 cycles -> q sequence 0..9,0..9,0..4. carry pulses exactly twice, on the cycles after q=9. wraps=2.
- load=1, load_val=3, then up=0, en=1, mode=wrap for 5 cycles -> q 3,2,1,0,9. tc high while q=0. One carry pulse. load_val=12 -> q=9 (clamped).
- mode=saturate, up=1, run 15 cycles from 0 -> q stops at 9 and holds. tc=1 stays set. carry never pulses. wraps=0.
- mode=one-shot, up=1 from 0 -> q reaches 9, done=1 on the next edge. Further en has no effect. clear -> q=0, done=0.
- Same-cycle load=1 and clear=1 with en=1 -> q=0 (clear wins). Reset asserted together with clear, load and en -> all outputs at reset values.
- WIDTH=4, MODULUS=16, up=1 for 17 cycles -> q 0..15,0 with no width overflow artefacts. wraps=1. Down from 0 -> q=15, carry=1.
